// File: rtl/bpsk_modulator.sv
// rtl/bpsk_modulator.sv - BPSK modulator: bit handshake, NCO sine carrier, +/-1 multiply, 2-stage output pipe
// Optional differential encoding of the bit stream when BPSK_DIFF_ENCODE_EN is defined.
module bpsk_modulator #(
  parameter int DATA_WIDTH         = 12,
  parameter int PHASE_WIDTH        = 24,
  parameter int LUT_ADDR_WIDTH     = 8,
  parameter int SAMPLES_PER_SYMBOL = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [PHASE_WIDTH-1:0]       fcw,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         dout_valid,
  output logic                         sym_strobe,
  output logic                         starve
);

  localparam int CNT_W     = $clog2(SAMPLES_PER_SYMBOL);
  localparam int LUT_DEPTH = 1 << LUT_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYMBOL - 1);

  typedef enum logic {IDLE, RUN} state_t;

  // Rounded half away from zero so the table is exactly symmetric and negation cannot overflow.
  function automatic logic signed [DATA_WIDTH-1:0] sine_entry(input int k);
    real amp;
    real ang;
    real v;
    amp = real'((1 << (DATA_WIDTH - 1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_DEPTH);
    v   = amp * $sin(ang);
    if (v >= 0.0) return DATA_WIDTH'($rtoi(v + 0.5));
    else          return DATA_WIDTH'(-$rtoi(0.5 - v));
  endfunction

  logic signed [DATA_WIDTH-1:0] sine_lut [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    assign sine_lut[k] = sine_entry(k);
  end

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [PHASE_WIDTH-1:0]       phase_q, phase_d;
  logic                         sym_q, sym_d;
  logic                         s1_valid_q, s1_valid_d;
  logic signed [DATA_WIDTH-1:0] s1_sample_q, s1_sample_d;
  logic                         s1_sym_q, s1_sym_d;
  logic                         s1_first_q, s1_first_d;
  logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                         dout_valid_q, dout_valid_d;
  logic                         sym_strobe_q, sym_strobe_d;
  logic                         starve_q, starve_d;

  logic gen;
  logic last;
  logic hs;
  logic coded_bit;

  assign gen       = (state_q == RUN) && en;
  assign last      = (cnt_q == CNT_LAST);
  assign bit_ready = (state_q == IDLE) || (gen && last);
  assign hs        = bit_valid && bit_ready;

`ifdef BPSK_DIFF_ENCODE_EN
  logic prev_q, prev_d;

  assign coded_bit = bit_in ^ prev_q;

  always_comb begin
    prev_d = prev_q;
    if (hs) prev_d = coded_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end
`else
  assign coded_bit = bit_in;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    sym_d    = sym_q;
    starve_d = starve_q;

    if (gen) begin
      phase_d = phase_q + fcw;
      if (!last) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!hs) begin
        state_d  = IDLE;
        starve_d = 1'b1;
      end
    end

    if (hs) begin
      sym_d   = coded_bit;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  // LUT is addressed with the pre-increment phase; each sample carries its own symbol through the pipe.
  always_comb begin
    s1_valid_d   = gen;
    s1_sample_d  = sine_lut[phase_q[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH]];
    s1_sym_d     = sym_q;
    s1_first_d   = (cnt_q == '0);

    dout_d       = '0;
    dout_valid_d = s1_valid_q;
    sym_strobe_d = s1_valid_q && s1_first_q;
    if (s1_valid_q) dout_d = s1_sym_q ? -s1_sample_q : s1_sample_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      phase_q      <= '0;
      sym_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_sample_q  <= '0;
      s1_sym_q     <= 1'b0;
      s1_first_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sym_strobe_q <= 1'b0;
      starve_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      sym_q        <= sym_d;
      s1_valid_q   <= s1_valid_d;
      s1_sample_q  <= s1_sample_d;
      s1_sym_q     <= s1_sym_d;
      s1_first_q   <= s1_first_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sym_strobe_q <= sym_strobe_d;
      starve_q     <= starve_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sym_strobe = sym_strobe_q;
  assign starve     = starve_q;

endmodule

// File: tb/tb_bpsk_modulator.sv
// tb/tb_bpsk_modulator.sv - directed self-checking bench for bpsk_modulator
module tb_bpsk_modulator;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [23:0]        fcw;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic signed [11:0] dout;
  logic               dout_valid;
  logic               sym_strobe;
  logic               starve;

  int n_checks = 0;
  int n_fail   = 0;

  // One carrier cycle at fcw=0x100000 (LUT step 16): round(2047*sin(k*22.5 deg)).
  int carrier [16] = '{0, 783, 1447, 1891, 2047, 1891, 1447, 783,
                       0, -783, -1447, -1891, -2047, -1891, -1447, -783};

  int cap_dout   [512];
  bit cap_strobe [512];
  int cap_n;
  int first_valid_cyc;
  bit starve_early;

  always #5 clk = ~clk;

  bpsk_modulator dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fcw        (fcw),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sym_strobe (sym_strobe),
    .starve     (starve)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bit_valid = 1'b0; en = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] bits, input int nbits, input bit toggle);
    int hs_cnt;
    bit hs_now;
    int limit;
    cap_n = 0; first_valid_cyc = -1; starve_early = 1'b0; hs_cnt = 0;
    limit = nbits * 64 * (toggle ? 2 : 1) + 20;
    bit_in = bits[0]; bit_valid = 1'b1; en = 1'b1;
    for (int cyc = 0; cyc < limit; cyc++) begin
      #1;
      hs_now = bit_valid && bit_ready;
      step();
      if (hs_now) begin
        hs_cnt++;
        if (hs_cnt < nbits) bit_in = bits[hs_cnt];
        else                bit_valid = 1'b0;
      end
      if (dout_valid && cap_n < 512) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        cap_dout[cap_n]   = int'(dout);
        cap_strobe[cap_n] = sym_strobe;
        cap_n++;
      end
      if (starve && hs_cnt < nbits) starve_early = 1'b1;
      en = toggle ? ~en : 1'b1;
    end
    bit_valid = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    en = 1'b1; bit_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (bit_ready !== 1'b1) begin n_fail++; $display("FAIL reset_bit_ready cyc %0d: got %b want 1", i, bit_ready); end
      n_checks++;
      if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid cyc %0d: got %b want 0", i, dout_valid); end
      n_checks++;
      if (dout !== 12'sd0) begin n_fail++; $display("FAIL reset_dout cyc %0d: got %0d want 0", i, dout); end
      n_checks++;
      if (starve !== 1'b0) begin n_fail++; $display("FAIL reset_starve cyc %0d: got %b want 0", i, starve); end
    end
  endtask

  task automatic test_single(input bit b);
    int exp_v;
    send_stream({7'b0, b}, 1, 1'b0);
    n_checks++;
    if (cap_n !== 64) begin n_fail++; $display("FAIL single%0d_count: got %0d want 64", b, cap_n); end
    n_checks++;
    if (first_valid_cyc !== 2) begin n_fail++; $display("FAIL single%0d_latency: got %0d want 2", b, first_valid_cyc); end
    for (int i = 0; i < cap_n && i < 64; i++) begin
      exp_v = b ? -carrier[i % 16] : carrier[i % 16];
      n_checks++;
      if (cap_dout[i] !== exp_v) begin n_fail++; $display("FAIL single%0d_dout[%0d]: got %0d want %0d", b, i, cap_dout[i], exp_v); end
      n_checks++;
      if (cap_strobe[i] !== (i == 0)) begin n_fail++; $display("FAIL single%0d_strobe[%0d]: got %b want %b", b, i, cap_strobe[i], (i == 0)); end
    end
    n_checks++;
    if (starve !== 1'b1) begin n_fail++; $display("FAIL single%0d_starve: got %b want 1", b, starve); end
    n_checks++;
    if (starve_early !== 1'b0) begin n_fail++; $display("FAIL single%0d_starve_early: got %b want 0", b, starve_early); end
    n_checks++;
    if (bit_ready !== 1'b1) begin n_fail++; $display("FAIL single%0d_idle_ready: got %b want 1", b, bit_ready); end
  endtask

  task automatic test_back_to_back();
    int exp_v;
    do_reset();
    send_stream(8'b10, 2, 1'b1);
    n_checks++;
    if (cap_n !== 128) begin n_fail++; $display("FAIL b2b_count: got %0d want 128", cap_n); end
    for (int i = 0; i < cap_n && i < 128; i++) begin
      exp_v = (i >= 64) ? -carrier[i % 16] : carrier[i % 16];
      n_checks++;
      if (cap_dout[i] !== exp_v) begin n_fail++; $display("FAIL b2b_dout[%0d]: got %0d want %0d", i, cap_dout[i], exp_v); end
      n_checks++;
      if (cap_strobe[i] !== (i == 0 || i == 64)) begin n_fail++; $display("FAIL b2b_strobe[%0d]: got %b want %b", i, cap_strobe[i], (i == 0 || i == 64)); end
    end
    n_checks++;
    if (cap_dout[65] !== -783) begin n_fail++; $display("FAIL b2b_sample65: got %0d want -783", cap_dout[65]); end
    n_checks++;
    if (starve_early !== 1'b0) begin n_fail++; $display("FAIL b2b_starve_early: got %b want 0", starve_early); end
    n_checks++;
    if (starve !== 1'b1) begin n_fail++; $display("FAIL b2b_starve_end: got %b want 1", starve); end
  endtask

  task automatic test_reset_mid();
    int seen;
    int guard;
    do_reset();
    bit_in = 1'b0; bit_valid = 1'b1; en = 1'b1;
    step();
    bit_valid = 1'b0;
    seen = 0; guard = 0;
    while (seen < 31 && guard < 100) begin
      step();
      if (dout_valid) seen++;
      guard++;
    end
    n_checks++;
    if (seen !== 31) begin n_fail++; $display("FAIL rstmid_reach_sample30: got %0d want 31", seen); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (dout !== 12'sd0) begin n_fail++; $display("FAIL rstmid_dout: got %0d want 0", dout); end
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_dout_valid: got %b want 0", dout_valid); end
    n_checks++;
    if (bit_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_bit_ready: got %b want 1", bit_ready); end
    n_checks++;
    if (starve !== 1'b0) begin n_fail++; $display("FAIL rstmid_starve: got %b want 0", starve); end
    step();
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_flush: got %b want 0", dout_valid); end
    send_stream(8'b0, 1, 1'b0);
    n_checks++;
    if (cap_n !== 64) begin n_fail++; $display("FAIL rstmid_restart_count: got %0d want 64", cap_n); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (cap_dout[i] !== carrier[i]) begin n_fail++; $display("FAIL rstmid_restart_dout[%0d]: got %0d want %0d", i, cap_dout[i], carrier[i]); end
    end
  endtask

  task automatic test_stream3();
    int exp_pk [3];
`ifdef BPSK_DIFF_ENCODE_EN
    exp_pk = '{-2047, 2047, 2047};
`else
    exp_pk = '{-2047, -2047, 2047};
`endif
    do_reset();
    send_stream(8'b011, 3, 1'b0);
    n_checks++;
    if (cap_n !== 192) begin n_fail++; $display("FAIL s3_count: got %0d want 192", cap_n); end
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (cap_dout[s * 64 + 4] !== exp_pk[s]) begin n_fail++; $display("FAIL s3_peak[%0d]: got %0d want %0d", s, cap_dout[s * 64 + 4], exp_pk[s]); end
      n_checks++;
      if (cap_strobe[s * 64] !== 1'b1) begin n_fail++; $display("FAIL s3_strobe[%0d]: got %b want 1", s, cap_strobe[s * 64]); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fcw = 24'h100000; bit_in = 1'b0; bit_valid = 1'b0;
    test_reset();
    test_single(1'b0);
    test_single(1'b1);
    test_back_to_back();
    test_reset_mid();
    test_stream3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
